// File: rtl/pipe_control.sv
// Pipeline control for a classic five-stage core: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control bundles, load-use and multiply-occupancy stalls, branch flush and jump detect.
module pipe_control #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned MD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             br_taken,
    output logic [3:0]       ex_ctrl,
    output logic [2:0]       mem_ctrl,
    output logic [1:0]       wb_ctrl,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic             jump,
    output logic             id_hold,
    output logic             flush,
    output logic             md_start
);

    localparam logic [3:0] MdLoad = 4'(MD_CYCLES - 1);

    // ID/EX carries all three bundles; later stages drop the parts already consumed.
    logic [3:0]       idex_ex_q,  idex_ex_d;
    logic [2:0]       idex_mem_q, idex_mem_d;
    logic [1:0]       idex_wb_q,  idex_wb_d;
    logic [REG_W-1:0] idex_dst_q, idex_dst_d;
    logic [2:0]       exmem_mem_q;
    logic [1:0]       exmem_wb_q;
    logic [REG_W-1:0] exmem_dst_q;
    logic [1:0]       memwb_wb_q;
    logic [REG_W-1:0] memwb_dst_q;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic             md_start_q, md_start_d;

    logic is_r, is_lw, is_sw, is_beq, is_bne, is_bgtz, is_j, is_jr, is_mult;
    logic is_andi, is_ori, is_addi, is_slti, is_imm, is_br, regwrite;
    logic [3:0]       dec_ex;
    logic [2:0]       dec_mem;
    logic [1:0]       dec_wb;
    logic [REG_W-1:0] dec_dst;
    logic             load_use, md_busy, bubble;

    always_comb begin
        is_r     = (op == 6'h00);
        is_lw    = (op == 6'h23);
        is_sw    = (op == 6'h2B);
        is_beq   = (op == 6'h04);
        is_bne   = (op == 6'h05);
        is_bgtz  = (op == 6'h07);
        is_j     = (op == 6'h02);
        is_jr    = is_r && (func == 6'h08);
        is_mult  = is_r && (func == 6'h18);
        is_andi  = (op == 6'h0C);
        is_ori   = (op == 6'h0D);
        is_addi  = (op == 6'h08);
        is_slti  = (op == 6'h0A);
        is_imm   = is_andi | is_ori | is_addi | is_slti;
        is_br    = is_beq | is_bne | is_bgtz;
        regwrite = (is_r & ~is_jr & ~is_mult) | is_lw | is_imm;

        dec_ex  = {is_r, is_lw | is_sw | is_imm, is_r | is_imm, is_br | is_imm};
        dec_mem = {is_br, is_lw, is_sw};
        dec_wb  = {is_lw, regwrite};
        dec_dst = regwrite ? (is_r ? rd : rt) : '0;
    end

    always_comb begin
        load_use = id_valid && idex_mem_q[1] && (idex_dst_q != '0) &&
                   ((idex_dst_q == rs) || (idex_dst_q == rt));
        md_busy  = (md_cnt_q != 4'd0);
        bubble   = ~id_valid | br_taken | load_use | md_busy;
        id_hold  = (load_use | md_busy) & ~br_taken;
        flush    = br_taken;
        jump     = id_valid & (is_j | is_jr) & ~br_taken & ~id_hold;

        idex_ex_d  = bubble ? 4'b0 : dec_ex;
        idex_mem_d = bubble ? 3'b0 : dec_mem;
        idex_wb_d  = bubble ? 2'b0 : dec_wb;
        idex_dst_d = bubble ? '0   : dec_dst;

        md_start_d = ~bubble & is_mult;
        // A branch squash leaves an already running multiply counting down.
        md_cnt_d   = md_cnt_q;
        if (md_start_d) begin
            md_cnt_d = MdLoad;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex_q   <= '0;
            idex_mem_q  <= '0;
            idex_wb_q   <= '0;
            idex_dst_q  <= '0;
            exmem_mem_q <= '0;
            exmem_wb_q  <= '0;
            exmem_dst_q <= '0;
            memwb_wb_q  <= '0;
            memwb_dst_q <= '0;
            md_cnt_q    <= '0;
            md_start_q  <= 1'b0;
        end else begin
            idex_ex_q   <= idex_ex_d;
            idex_mem_q  <= idex_mem_d;
            idex_wb_q   <= idex_wb_d;
            idex_dst_q  <= idex_dst_d;
            exmem_mem_q <= idex_mem_q;
            exmem_wb_q  <= idex_wb_q;
            exmem_dst_q <= idex_dst_q;
            memwb_wb_q  <= exmem_wb_q;
            memwb_dst_q <= exmem_dst_q;
            md_cnt_q    <= md_cnt_d;
            md_start_q  <= md_start_d;
        end
    end

    assign ex_ctrl  = idex_ex_q;
    assign mem_ctrl = exmem_mem_q;
    assign wb_ctrl  = memwb_wb_q;
    assign ex_dst   = idex_dst_q;
    assign mem_dst  = exmem_dst_q;
    assign wb_dst   = memwb_dst_q;
    assign md_start = md_start_q;

endmodule
